// File: rtl/mirfak_lsu_if.sv
// mirfak_lsu_if: data-side Wishbone bus between the LSU and memory
interface mirfak_lsu_if;
  logic [31:0] dwbm_addr_o;
  logic [31:0] dwbm_dat_o;
  logic [31:0] dwbm_dat_i;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_cyc_o;
  logic        dwbm_stb_o;
  logic        dwbm_we_o;
  logic        dwbm_ack_i;
  logic        dwbm_err_i;
  modport master (
    output dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
    input  dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );
  modport slave (
    input  dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
    output dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );
endinterface

// File: rtl/mirfak_lsu.sv
// mirfak_lsu: load/store unit issuing one Wishbone cycle per WB-stage memory op
module mirfak_lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lsu_address_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic        lsu_load_i,
  input  logic        lsu_store_i,
  input  logic        lsu_enable_i,
  input  logic        lsu_kill_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_busy_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_error_o,
  mirfak_lsu_if.master dwbm
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic        ld;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        start;
  logic [31:0] sh;
  logic [31:0] ext;
  always_comb begin
    is_b = lsu_funct3_i[1:0] == 2'b00;
    is_h = lsu_funct3_i[1:0] == 2'b01;
    is_w = !is_b && !is_h;
    lsu_misaligned_o = (lsu_load_i | lsu_store_i) & lsu_enable_i &
                       ((is_h & lsu_address_i[0]) | (is_w & (|lsu_address_i[1:0])));
    start = lsu_enable_i & (lsu_load_i | lsu_store_i) & !lsu_misaligned_o & !lsu_kill_i & (state == IDLE);
    lsu_busy_o = start | (state == BUSY);
    sh = dwbm.dwbm_dat_i >> {off, 3'b000};
    // funct3[2] set means the unsigned variant, so the fill bit is forced to zero
    ext = f3[1:0] == 2'b00 ? {{24{sh[7] & !f3[2]}}, sh[7:0]} :
          f3[1:0] == 2'b01 ? {{16{sh[15] & !f3[2]}}, sh[15:0]} : dwbm.dwbm_dat_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      dwbm.dwbm_cyc_o <= 1'b0;
      dwbm.dwbm_stb_o <= 1'b0;
      dwbm.dwbm_we_o <= 1'b0;
      dwbm.dwbm_sel_o <= 4'b0;
      dwbm.dwbm_addr_o <= 32'b0;
      dwbm.dwbm_dat_o <= 32'b0;
      lsu_rdata_o <= 32'b0;
      lsu_error_o <= 1'b0;
      off <= 2'b0;
      f3 <= 3'b0;
      ld <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= BUSY;
          dwbm.dwbm_cyc_o <= 1'b1;
          dwbm.dwbm_stb_o <= 1'b1;
          dwbm.dwbm_we_o <= lsu_store_i;
          dwbm.dwbm_addr_o <= {lsu_address_i[31:2], 2'b00};
          dwbm.dwbm_sel_o <= is_b ? 4'b0001 << lsu_address_i[1:0] :
                             is_h ? 4'b0011 << {lsu_address_i[1], 1'b0} : 4'b1111;
          dwbm.dwbm_dat_o <= is_b ? {4{lsu_wdata_i[7:0]}} :
                             is_h ? {2{lsu_wdata_i[15:0]}} : lsu_wdata_i;
          off <= lsu_address_i[1:0];
          f3 <= lsu_funct3_i;
          ld <= lsu_load_i;
        end
        BUSY: if (dwbm.dwbm_ack_i | dwbm.dwbm_err_i) begin
          state <= DONE;
          dwbm.dwbm_cyc_o <= 1'b0;
          dwbm.dwbm_stb_o <= 1'b0;
          if (dwbm.dwbm_err_i) begin
            lsu_rdata_o <= 32'b0;
            lsu_error_o <= 1'b1;
          end else if (ld)
            lsu_rdata_o <= ext;
        end
        default: begin
          state <= IDLE;
          lsu_error_o <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_mirfak_lsu.sv
// tb_mirfak_lsu: directed and randomized checks of mirfak_lsu against a byte-level model
module tb_mirfak_lsu;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] lsu_address_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic [2:0]  lsu_funct3_i = '0;
  logic        lsu_load_i = 1'b0;
  logic        lsu_store_i = 1'b0;
  logic        lsu_enable_i = 1'b0;
  logic        lsu_kill_i = 1'b0;
  logic [31:0] lsu_rdata_o;
  logic        lsu_busy_o;
  logic        lsu_misaligned_o;
  logic        lsu_error_o;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = '0;
  mirfak_lsu_if bus();
  mirfak_lsu dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .lsu_address_i(lsu_address_i),
    .lsu_wdata_i(lsu_wdata_i),
    .lsu_funct3_i(lsu_funct3_i),
    .lsu_load_i(lsu_load_i),
    .lsu_store_i(lsu_store_i),
    .lsu_enable_i(lsu_enable_i),
    .lsu_kill_i(lsu_kill_i),
    .lsu_rdata_o(lsu_rdata_o),
    .lsu_busy_o(lsu_busy_o),
    .lsu_misaligned_o(lsu_misaligned_o),
    .lsu_error_o(lsu_error_o),
    .dwbm(bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int nbytes(input logic [2:0] f);
    return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
  endfunction
  function automatic logic exp_mis(input logic [2:0] f, input logic [31:0] a);
    return (a % nbytes(f)) != 0;
  endfunction
  function automatic logic [3:0] exp_sel(input logic [2:0] f, input logic [31:0] a);
    return 4'(((32'd1 << nbytes(f)) - 32'd1) << a[1:0]);
  endfunction
  function automatic logic [31:0] exp_dat(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(f);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] exp_rd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] m;
    int n;
    n = nbytes(f);
    if (n == 4) return d;
    m = (32'd1 << (8 * n)) - 32'd1;
    v = (d >> (8 * a[1:0])) & m;
    if (!f[2] && v[8*n-1]) v = v | ~m;
    return v;
  endfunction
  task automatic access(input bit ld, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int k, input bit e, input bit both, input bit kmid);
    int busy_n;
    int cyc_n;
    bit hit;
    busy_n = 1;
    cyc_n = 0;
    hit = 0;
    @(negedge clk_i);
    lsu_enable_i = 1'b1;
    lsu_load_i = ld;
    lsu_store_i = !ld;
    lsu_funct3_i = f;
    lsu_address_i = a;
    lsu_wdata_i = wd;
    lsu_kill_i = 1'b0;
    #1 check("start_busy", 32'(lsu_busy_o), 32'd1);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk_i);
      bus.dwbm_ack_i = 1'b0;
      bus.dwbm_err_i = 1'b0;
      if (c == 0) begin
        check("cyc", 32'(bus.dwbm_cyc_o), 32'd1);
        check("stb", 32'(bus.dwbm_stb_o), 32'd1);
        check("we", 32'(bus.dwbm_we_o), 32'(!ld));
        check("addr", bus.dwbm_addr_o, a & ~32'd3);
        check("sel", 32'(bus.dwbm_sel_o), 32'(exp_sel(f, a)));
        check("dat_o", bus.dwbm_dat_o, exp_dat(f, wd));
        lsu_load_i = 1'($urandom);
        lsu_store_i = !lsu_load_i;
        lsu_address_i = $urandom;
        lsu_funct3_i = 3'($urandom);
        lsu_wdata_i = $urandom;
        lsu_kill_i = kmid;
      end
      if (lsu_busy_o) busy_n++;
      if (bus.dwbm_cyc_o) cyc_n++;
      if (cyc_n == k) begin
        hit = 1;
        bus.dwbm_err_i = e;
        bus.dwbm_ack_i = !e || both;
        bus.dwbm_dat_i = rd;
      end
    end
    check("ack_reached", 32'(hit), 32'd1);
    @(negedge clk_i);
    if (e) model_rdata = 32'd0;
    else if (ld) model_rdata = exp_rd(f, a, rd);
    check("busy_cycles", 32'(busy_n), 32'(k + 1));
    check("done_busy", 32'(lsu_busy_o), 32'd0);
    check("done_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
    check("done_error", 32'(lsu_error_o), 32'(e));
    check("done_rdata", lsu_rdata_o, model_rdata);
    bus.dwbm_ack_i = 1'b1;
    bus.dwbm_err_i = 1'b0;
    bus.dwbm_dat_i = $urandom;
    lsu_enable_i = 1'b0;
    lsu_kill_i = 1'b0;
    @(negedge clk_i);
    check("idle_error", 32'(lsu_error_o), 32'd0);
    check("idle_rdata", lsu_rdata_o, model_rdata);
    bus.dwbm_ack_i = 1'b0;
    @(negedge clk_i);
    check("idle_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
    check("held_rdata", lsu_rdata_o, model_rdata);
  endtask
  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    bus.dwbm_ack_i = 1'b0;
    bus.dwbm_err_i = 1'b0;
    bus.dwbm_dat_i = '0;
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
    check("rst_stb", 32'(bus.dwbm_stb_o), 32'd0);
    check("rst_we", 32'(bus.dwbm_we_o), 32'd0);
    check("rst_sel", 32'(bus.dwbm_sel_o), 32'd0);
    check("rst_addr", bus.dwbm_addr_o, 32'd0);
    check("rst_dat_o", bus.dwbm_dat_o, 32'd0);
    check("rst_rdata", lsu_rdata_o, 32'd0);
    check("rst_error", 32'(lsu_error_o), 32'd0);
    check("rst_busy", 32'(lsu_busy_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    access(1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 3, 1'b0, 1'b0, 1'b0);
    check("lb_sign", lsu_rdata_o, 32'hFFFF_FF80);
    access(1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    lsu_enable_i = 1'b1;
    lsu_load_i = 1'b1;
    lsu_store_i = 1'b0;
    lsu_funct3_i = 3'b010;
    lsu_address_i = 32'h101;
    #1;
    check("mis_flag", 32'(lsu_misaligned_o), 32'd1);
    check("mis_busy", 32'(lsu_busy_o), 32'd0);
    repeat (3) begin
      @(negedge clk_i);
      check("mis_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
    end
    lsu_enable_i = 1'b0;
    access(1'b1, 3'b101, 32'h002, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 1'b0);
    access(1'b1, 3'b010, 32'h100, 32'h0, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    lsu_enable_i = 1'b1;
    lsu_kill_i = 1'b1;
    lsu_load_i = 1'b1;
    lsu_funct3_i = 3'b010;
    lsu_address_i = 32'h40;
    #1 check("kill_busy", 32'(lsu_busy_o), 32'd0);
    repeat (2) begin
      @(negedge clk_i);
      check("kill_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
    end
    lsu_enable_i = 1'b0;
    lsu_kill_i = 1'b0;
    access(1'b1, 3'b100, 32'h001, 32'h0, 32'h0000_9900, 1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    lsu_enable_i = 1'b1;
    lsu_load_i = 1'b1;
    lsu_store_i = 1'b0;
    lsu_funct3_i = 3'b000;
    lsu_address_i = 32'h40;
    @(negedge clk_i);
    lsu_enable_i = 1'b0;
    check("pre_rst_cyc", 32'(bus.dwbm_cyc_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
    check("async_stb", 32'(bus.dwbm_stb_o), 32'd0);
    check("async_busy", 32'(lsu_busy_o), 32'd0);
    model_rdata = 32'd0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    access(1'b1, 3'b001, 32'h402, 32'h0, 32'h8001_7FFF, 2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      @(negedge clk_i);
      lsu_enable_i = 1'b1;
      lsu_load_i = 1'($urandom);
      lsu_store_i = !lsu_load_i;
      lsu_funct3_i = rf;
      lsu_address_i = ra;
      #1 check("rand_mis", 32'(lsu_misaligned_o), 32'(exp_mis(rf, ra)));
      lsu_enable_i = 1'b0;
      ra = ra & ~32'(nbytes(rf) - 1);
      access(1'($urandom), rf, ra, $urandom, $urandom, $urandom_range(1, 4),
             $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mirfak_lsu.md
MIRFAK_LSU -- requirements
Module: mirfak_lsu

Interface
REQ-001 SHALL have parameter: none; behaviour is fixed, with no configuration knobs.
REQ-002 SHALL have port: clk_i  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: lsu_address_i  in  32  effective address from EX/WB ALU result register.
REQ-005 SHALL have port: lsu_wdata_i  in  32  store data from EX/WB register.
REQ-006 SHALL have port: lsu_funct3_i  in  3  instruction[14:12] (size/sign).
REQ-007 SHALL have ports: lsu_load_i, lsu_store_i  in  1 each  op type; never both high.
REQ-008 SHALL have port: lsu_enable_i  in  1  WB holds valid, non-bubble, exception-free instruction.
REQ-009 SHALL have port: lsu_kill_i  in  1  flush; blocks start of a new access.
REQ-010 SHALL have port: lsu_rdata_o  out  32  aligned, extended load data.
REQ-011 SHALL have ports: lsu_busy_o, lsu_misaligned_o, lsu_error_o  out  1 each  stall, alignment fault, bus fault.
REQ-012 SHALL have ports: dwbm_addr_o 32, dwbm_dat_o 32, dwbm_sel_o 4, dwbm_cyc_o/dwbm_stb_o/dwbm_we_o 1  out  Wishbone master.
REQ-013 SHALL have ports: dwbm_dat_i 32, dwbm_ack_i 1, dwbm_err_i 1  in  Wishbone responses.

Function
REQ-014 SHALL have funct3 map: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other code SHALL be treated as word.
REQ-015 SHALL compute lsu_misaligned_o combinationally: (load|store) & enable & ((half & addr[0]) | (word & addr[1:0]!=0)); byte never misaligned.
REQ-016 SHALL have start = enable & (load|store) & !misaligned & !kill & state==IDLE.
REQ-017 SHALL use FSM states IDLE, BUSY, DONE: IDLE->BUSY on start; BUSY->DONE on ack|err; DONE->IDLE unconditionally next cycle.
REQ-018 SHALL register dwbm_* outputs on start; cyc=stb=1 from first BUSY cycle until the cycle after ack|err; addr={addr[31:2],2'b00}; we=store.
REQ-019 SHALL set dwbm_sel_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-020 SHALL replicate dwbm_dat_o: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-021 SHALL capture on ack during load: dwbm_dat_i >> (8*addr[1:0]), then sign- (LB/LH) or zero- (LBU/LHU) extended; LW unshifted; result held in lsu_rdata_o from DONE until next capture.
REQ-022 SHALL, on err: end transaction like ack, set lsu_rdata_o=0, and assert lsu_error_o for the DONE cycle only.
REQ-023 SHALL have lsu_busy_o = start | (state==BUSY); 0 in DONE so pipeline advances exactly once; minimum load/store latency 2 cycles (start cycle + ack cycle).
REQ-024 SHALL have address/funct3/load flag latched at start; input changes during BUSY ignored.
REQ-025 SHALL ignore lsu_kill_i during BUSY: an issued bus cycle always completes (no abort).
REQ-026 SHALL, on simultaneous ack and err, treat err as having priority.
REQ-027 SHALL not start a bus cycle and keep busy=0 on misalignment; trap is taken by the exception unit.
REQ-028 SHALL ignore ack/err in IDLE and DONE.

Reset
REQ-029 SHALL, with rst_ni low, asynchronously force state=IDLE, cyc=stb=we=0, sel=0, addr=0, dat_o=0, lsu_rdata_o=0, lsu_error_o=0; mid-transaction reset drops cyc/stb immediately.
REQ-030 SHALL leave the module in IDLE, ready to start on the first enabled cycle, after rst_ni rises.

Verification
REQ-031 SHALL cover: LB addr 0x103, ack with dat_i 0x80FF_1234 after 3 wait cycles -> sel 1000, rdata 0xFFFF_FF80, busy 4 cycles.
REQ-032 SHALL cover: SH addr 0x202, wdata 0x1234_ABCD -> addr 0x200, sel 1100, dat_o 0xABCD_ABCD, we=1.
REQ-033 SHALL cover: LW addr 0x101 -> misaligned=1, cyc never asserted, busy=0.
REQ-034 SHALL cover: LHU addr 0x02, err in 2nd BUSY cycle -> error=1 for one cycle, rdata 0.
REQ-035 SHALL cover: kill during BUSY -> cycle completes on ack; kill with request in IDLE -> no cyc.
REQ-036 SHALL cover: rst_ni low in BUSY -> cyc/stb 0 asynchronously; next load after release behaves normally.
